instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sequential producer of the single-cycle core's instruction word and operation fields (op_code, funct), the other end of the main-decoder interface.
- Owns the PC register, the instruction-memory request handshake and the instruction register (IR).
- Consumes the decoder's branch and jump controls and the ALU zero flag to compute the next PC once the datapath signals that the current instruction has retired.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  instruction fetch request, held until imem_valid
- imem_addr  output  32  fetch address; equals pc
- imem_rdata  input  32  instruction word; sampled only when imem_valid=1 in FETCH
- imem_valid  input  1  response strobe, may arrive 0..N cycles after imem_req
- exec_done  input  1  one-cycle pulse from datapath: current instruction retired
- branch  input  1  decoder branch control (beq)
- jump  input  1  decoder jump control
- alu_zero  input  1  ALU zero flag for the current instruction
- instr_valid  output  1  IR contents valid for decode and execute
- instr  output  32  IR contents
- op_code  output  6  instr[31:26]
- funct  output  6  instr[5:0]
- pc  output  32  address of the instruction in IR
- pc_plus4  output  32  pc + 4
- retired_count  output  32  number of exec_done pulses accepted in HOLD; wraps

Behaviour:
- Reset (reset=1 at a clock edge):
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired_count=0.
  - Reset wins over every other input in the same cycle.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE -> FETCH unconditionally on the next edge. imem_req=0 in IDLE.
  - FETCH: imem_req=1, imem_addr=pc.
    - imem_valid=1: IR <= imem_rdata; go to HOLD.
    - Otherwise remain in FETCH with imem_req held high.
  - HOLD: instr_valid=1, imem_req=0; IR and pc stable.
    - exec_done=1: pc <= next_pc; retired_count += 1; go to FETCH.
- Latency:
  - imem_valid in cycle M -> instr_valid=1 in cycle M+1.
  - exec_done in cycle K -> new pc and imem_req=1 in cycle K+1; instr_valid=0 in cycle K+1.
  - Minimum loop is 2 cycles per instruction with zero-wait memory.
- next_pc is computed combinationally from IR and pc:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}. Jump has priority over branch.
  - branch=1 and alu_zero=1: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), mod 2^32.
  - Otherwise: pc_plus4.
  - branch=1 with alu_zero=0 falls through to pc_plus4.
- Arithmetic:
  - All PC arithmetic is 32-bit and wraps; 32'hFFFF_FFFC + 4 = 0.
  - retired_count wraps from 32'hFFFF_FFFF to 0.
- Ignored inputs:
  - imem_valid outside FETCH is ignored.
  - exec_done outside HOLD is ignored; retired_count does not change.
  - branch, jump and alu_zero are sampled only on the accepted exec_done edge.
- Reset mid-operation:
  - A reset during FETCH abandons the request (imem_req=0 next cycle).
  - An imem_valid arriving in the reset cycle or in IDLE is discarded; IR stays 0.
- op_code and funct are pure slices of IR, so they are 0 after reset until the first fetch completes.

Test Plan:
- Reset, zero-wait memory returning 32'h2008_0005 (addi) at addr 0:
  - imem_req=1 at cycle 1, instr_valid=1 at cycle 2, op_code=6'b001000.
  - exec_done then refetches at pc=4.
- Three-cycle memory wait:
  - imem_req stays 1 and imem_addr stays constant for 3 cycles.
  - instr_valid rises exactly one cycle after imem_valid.
- beq at pc=32'h10, imm=16'hFFFC, branch=1, alu_zero=1:
  - next pc = 32'h14 + (-16) = 32'h04.
  - Same instruction with alu_zero=0 gives pc=32'h14.
- j at pc=32'h4000_0008, instr[25:0]=26'h000_0040:
  - next pc = 32'h4000_0100.
  - With jump=1 and branch=1 together, the jump target wins.
- Spurious inputs:
  - exec_done pulsed in FETCH and imem_valid pulsed in HOLD: no state change, retired_count unchanged.
- Reset asserted while FETCH is waiting, with imem_valid=1 in the same cycle:
  - IR=0, pc=RESET_PC, imem_req=0 for one cycle, then refetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage of the single-cycle core. It owns the PC, the instruction-memory
// request handshake and the instruction register (IR). It also computes the
// next PC from the decoder's branch/jump controls and the ALU zero flag once
// the datapath reports that the current instruction has retired.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   imem_req       fetch request, held high until imem_valid
//   imem_addr      fetch address (always equal to pc)
//   imem_rdata     instruction word, captured on imem_valid in FETCH
//   imem_valid     memory response strobe
//   exec_done      one-cycle retire pulse from the datapath
//   branch         decoder branch control (beq)
//   jump           decoder jump control
//   alu_zero       ALU zero flag of the current instruction
//   instr_valid    IR holds an instruction ready for decode/execute
//   instr          IR contents
//   op_code        instr[31:26]
//   funct          instr[5:0]
//   pc             address of the instruction in IR
//   pc_plus4       pc + 4
//   retired_count  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        jump,
  input  logic        alu_zero,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op_code,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] branch_off_s;
  logic [31:0] next_pc_s;

  // Next-PC selection; jump has priority over a taken branch.
  always_comb begin
    pc_plus4_s   = pc_q + 32'd4;
    branch_off_s = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    next_pc_s    = pc_plus4_s;
    if (jump) begin
      next_pc_s = {pc_plus4_s[31:28], ir_q[25:0], 2'b00};
    end else if (branch && alu_zero) begin
      next_pc_s = pc_plus4_s + branch_off_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_HOLD;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (exec_done) begin
          pc_d      = next_pc_s;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Handshake outputs are registered copies of the upcoming state.
    imem_req_d    = (state_d == S_FETCH);
    instr_valid_d = (state_d == S_HOLD);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= 32'h0000_0000;
      retired_q     <= 32'h0000_0000;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      retired_q     <= retired_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = pc_q;
  assign instr_valid   = instr_valid_q;
  assign instr         = ir_q;
  assign op_code       = ir_q[31:26];
  assign funct         = ir_q[5:0];
  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_s;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        exec_done;
  logic        branch;
  logic        jump;
  logic        alu_zero;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op_code;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model: fetch outstanding / instruction held flags
  logic        m_fetching;
  logic        m_holding;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic [31:0] m_cnt;

  instr_fetch_unit #(.RESET_PC(RST_PC)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .exec_done     (exec_done),
    .branch        (branch),
    .jump          (jump),
    .alu_zero      (alu_zero),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .op_code       (op_code),
    .funct         (funct),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural update of the model for one clock edge.
  task automatic model_edge();
    logic [31:0] target;
    logic [31:0] off;
    if (reset) begin
      m_fetching = 1'b0;
      m_holding  = 1'b0;
      m_pc       = RST_PC;
      m_ir       = 32'd0;
      m_cnt      = 32'd0;
    end else if (m_fetching) begin
      if (imem_valid) begin
        m_ir       = imem_rdata;
        m_fetching = 1'b0;
        m_holding  = 1'b1;
      end
    end else if (m_holding) begin
      if (exec_done) begin
        if (jump) begin
          target = ((m_pc + 32'd4) & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
        end else if (branch && alu_zero) begin
          off    = (m_ir[15] ? (m_ir | 32'hFFFF_0000) : (m_ir & 32'h0000_FFFF)) << 2;
          target = m_pc + 32'd4 + off;
        end else begin
          target = m_pc + 32'd4;
        end
        m_pc       = target;
        m_cnt      = m_cnt + 32'd1;
        m_holding  = 1'b0;
        m_fetching = 1'b1;
      end
    end else begin
      m_fetching = 1'b1;
    end
  endtask

  task automatic compare_all();
    check_val("imem_req",    {31'd0, imem_req},    {31'd0, m_fetching});
    check_val("imem_addr",   imem_addr,            m_pc);
    check_val("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
    check_val("instr",       instr,                m_ir);
    check_val("op_code",     {26'd0, op_code},     m_ir >> 26);
    check_val("funct",       {26'd0, funct},       m_ir & 32'h0000_003F);
    check_val("pc",          pc,                   m_pc);
    check_val("pc_plus4",    pc_plus4,             m_pc + 32'd4);
    check_val("retired",     retired_count,        m_cnt);
  endtask

  // Apply one cycle of inputs, advance the model and compare after the edge.
  task automatic cyc(input logic r, input logic v, input logic [31:0] rd,
                     input logic ed, input logic br, input logic jp, input logic z);
    reset      = r;
    imem_valid = v;
    imem_rdata = rd;
    exec_done  = ed;
    branch     = br;
    jump       = jp;
    alu_zero   = z;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] cnt_before;
    m_fetching = 1'b0;
    m_holding  = 1'b0;
    m_pc       = RST_PC;
    m_ir       = 32'd0;
    m_cnt      = 32'd0;

    // reset
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("rst_pc", pc, 32'h0000_0000);
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_ir", instr, 32'd0);

    // zero-wait addi at 0
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("c1_req", {31'd0, imem_req}, 32'd1);
    cyc(1'b0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("c2_valid", {31'd0, instr_valid}, 32'd1);
    check_val("c2_opcode", {26'd0, op_code}, 32'h0000_0008);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("refetch_pc", imem_addr, 32'h0000_0004);
    check_val("refetch_iv", {31'd0, instr_valid}, 32'd0);

    // three-cycle wait, then j to 0x10
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'hBAD0_0000, 1'b0, 1'b0, 1'b0, 1'b0);
      check_val("wait_addr", imem_addr, 32'h0000_0004);
    end
    cyc(1'b0, 1'b1, 32'h0800_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("wait_iv", {31'd0, instr_valid}, 32'd1);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("j_to_10", pc, 32'h0000_0010);

    // beq taken at 0x10 -> 0x04
    cyc(1'b0, 1'b1, 32'h1000_FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("beq_taken", pc, 32'h0000_0004);
    // back to 0x10, beq not taken -> 0x14
    cyc(1'b0, 1'b1, 32'h0800_0004, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 32'h1000_FFFC, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("beq_not_taken", pc, 32'h0000_0014);

    // climb to the 0x4xxx_xxxx region with maximal forward branches
    for (int i = 0; i < 9000 && m_pc[31:28] != 4'h4; i++) begin
      cyc(1'b0, 1'b1, 32'h1000_7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    end
    check_val("climb_pc", pc, 32'h4000_0014);
    cyc(1'b0, 1'b1, 32'h0800_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("j_to_4000_0008", pc, 32'h4000_0008);
    cyc(1'b0, 1'b1, 32'h0800_0040, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_val("j_target", pc, 32'h4000_0100);
    cyc(1'b0, 1'b1, 32'h0800_0040, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_val("j_over_beq", pc, 32'h4000_0100);

    // spurious exec_done in FETCH, spurious imem_valid in HOLD
    cnt_before = m_cnt;
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("spur_exec_cnt", retired_count, cnt_before);
    check_val("spur_exec_pc", pc, 32'h4000_0100);
    cyc(1'b0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("spur_valid_ir", instr, 32'h2008_0005);
    check_val("spur_valid_iv", {31'd0, instr_valid}, 32'd1);

    // reset while waiting in FETCH with imem_valid in the same cycle
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("mid_rst_ir", instr, 32'd0);
    check_val("mid_rst_pc", pc, RST_PC);
    check_val("mid_rst_req", {31'd0, imem_req}, 32'd0);
    cyc(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("idle_valid_ir", instr, 32'd0);
    check_val("refetch_req", {31'd0, imem_req}, 32'd1);

    // PC wrap: beq -8 from 0 -> 0xFFFF_FFFC, then fall-through to 0
    cyc(1'b0, 1'b1, 32'h1000_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_val("wrap_pc", pc, 32'hFFFF_FFFC);
    check_val("wrap_pc4", pc_plus4, 32'h0000_0000);
    cyc(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("funct_add", {26'd0, funct}, 32'h0000_0020);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("wrap_next", pc, 32'h0000_0000);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)),
          $urandom(),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
